// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } md_state_e;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: sign-magnitude operands, one bit per cycle
// through a shared 64-bit accumulator, sign fixup, then a one-cycle valid result.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [2:0]      funct3E,
    output logic            StallMD,
    output logic            MulDivValidE,
    output logic [XLEN-1:0] MulDivResultE
);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              valid_q, valid_d;

    // Operand decode at issue time
    logic            is_div, a_signed, b_signed, sign_a, sign_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;

    assign is_div   = funct3E[2];
    assign a_signed = is_div ? ~funct3E[0] : (funct3E != MD_MULHU);
    assign b_signed = is_div ? ~funct3E[0] : (funct3E == MD_MULH);
    assign sign_a   = a_signed & SrcAE[XLEN-1];
    assign sign_b   = b_signed & SrcBE[XLEN-1];
    assign mag_a    = sign_a ? -SrcAE : SrcAE;
    assign mag_b    = sign_b ? -SrcBE : SrcBE;
    assign div_zero = is_div && (SrcBE == '0);
    assign div_ovf  = is_div && !funct3E[0] && (SrcAE == INT_MIN) && (SrcBE == '1);

    // One shift-add multiply step: acc = {partial product, remaining multiplier bits}
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : (XLEN+1)'(0));
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // One restoring divide step: acc = {remainder, dividend/quotient shift register}
    logic [XLEN:0]     div_part, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;

    assign div_part = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_part - {1'b0, opa_q};
    assign div_ge   = div_part >= {1'b0, opa_q};
    assign div_rem  = div_ge ? div_diff[XLEN-1:0] : div_part[XLEN-1:0];
    assign div_next = {div_rem, acc_q[XLEN-2:0], div_ge};

    // Sign fixup and word select
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_result = quot_fix;
        case (op_q)
            MD_MUL:                        fix_result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
            MD_REM, MD_REMU:               fix_result = rem_fix;
            default:                       fix_result = quot_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opa_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opa_q    <= opa_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opa_d    = opa_q;
        acc_d    = acc_q;
        result_d = result_q;
        valid_d  = 1'b0;
        StallMD  = 1'b0;

        case (state_q)
            IDLE: begin
                if (StartE && !FlushE) begin
                    StallMD = 1'b1;
                    op_d    = funct3E;
                    if (div_zero) begin
                        result_d = funct3E[1] ? SrcAE : DIV0_QUOT;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = funct3E[1] ? '0 : INT_MIN;
                        state_d  = DONE;
                    end else begin
                        neg_d   = (is_div && funct3E[1]) ? sign_a : (sign_a ^ sign_b);
                        opa_d   = is_div ? mag_b : mag_a;
                        acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
                        count_d = CNT_W'(31);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                StallMD = 1'b1;
                acc_d   = op_q[2] ? div_next : mul_next;
                count_d = count_q - CNT_W'(1);
                if (count_q == '0) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                StallMD  = 1'b1;
                result_d = fix_result;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over everything, including a start in the same cycle
        if (FlushE) begin
            state_d  = IDLE;
            result_d = result_q;
        end
        valid_d = (state_d == DONE);
    end

    assign MulDivValidE  = valid_q;
    assign MulDivResultE = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
    localparam logic [31:0] IMIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StartE, FlushE;
    logic [31:0] SrcAE, SrcBE;
    logic [2:0]  funct3E;
    logic        StallMD, MulDivValidE;
    logic [31:0] MulDivResultE;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_res = '0;

    muldiv_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .StartE        (StartE),
        .FlushE        (FlushE),
        .SrcAE         (SrcAE),
        .SrcBE         (SrcBE),
        .funct3E       (funct3E),
        .StallMD       (StallMD),
        .MulDivValidE  (MulDivValidE),
        .MulDivResultE (MulDivResultE)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from 64-bit signed/unsigned arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            F_MUL:    begin p = sa * sb;          return p[31:0];  end
            F_MULH:   begin p = sa * sb;          return p[63:32]; end
            F_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            F_MULHU:  begin p = ua * ub;          return p[63:32]; end
            F_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == IMIN && b == 32'hFFFF_FFFF) return IMIN;
                return $signed(a) / $signed(b);
            end
            F_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            F_REM: begin
                if (b == 0) return a;
                if (a == IMIN && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == IMIN && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return IMIN;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Entered just after a rising edge; that cycle is cycle 0 of the op.
    // Returns just after the edge that starts the IDLE cycle following DONE.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res);
        int lat;
        lat = is_special(f, a, b) ? 1 : 34;
        StartE = 1'b1; funct3E = f; SrcAE = a; SrcBE = b;
        for (int cyc = 0; cyc <= lat; cyc++) begin
            @(negedge clk);
            check({tag, "_stall"}, 32'(StallMD), 32'(cyc < lat));
            check({tag, "_valid"}, 32'(MulDivValidE), 32'(cyc == lat));
            if (cyc == lat) check({tag, "_result"}, MulDivResultE, exp_res);
            @(posedge clk); #1;
            SrcAE = $urandom; SrcBE = $urandom;
        end
        StartE = 1'b0;
        last_res = exp_res;
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        bit          saw_valid;

        rst_n = 1'b0; StartE = 1'b0; FlushE = 1'b0;
        SrcAE = '0; SrcBE = '0; funct3E = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", MulDivResultE, 32'h0);
        check("rst_valid", 32'(MulDivValidE), 32'h0);
        check("rst_stall", 32'(StallMD), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("mul_7x-3",   F_MUL,    32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        do_op("mulh_m1",    F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        do_op("mulhu_m1",   F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("mulhsu_m1",  F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("div_-7_2",   F_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_op("rem_-7_2",   F_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_op("divu_100_7", F_DIVU,   32'd100, 32'd7, 32'd14);
        do_op("remu_100_7", F_REMU,   32'd100, 32'd7, 32'd2);
        do_op("divu_5_0",   F_DIVU,   32'd5, 32'd0, 32'hFFFF_FFFF);
        do_op("rem_5_0",    F_REM,    32'd5, 32'd0, 32'd5);
        do_op("div_ovf",    F_DIV,    IMIN, 32'hFFFF_FFFF, IMIN);
        do_op("rem_ovf",    F_REM,    IMIN, 32'hFFFF_FFFF, 32'h0);

        // Flush a DIV in cycle 10
        StartE = 1'b1; funct3E = F_DIV; SrcAE = 32'd1000; SrcBE = 32'd7;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc == 10) FlushE = 1'b1;
            @(negedge clk);
            check("flush_pre_stall", 32'(StallMD), 32'h1);
            @(posedge clk); #1;
        end
        FlushE = 1'b0; StartE = 1'b0;
        @(negedge clk);
        check("flush_stall", 32'(StallMD), 32'h0);
        check("flush_valid", 32'(MulDivValidE), 32'h0);
        check("flush_result_held", MulDivResultE, last_res);
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (MulDivValidE !== 1'b0) saw_valid = 1'b1;
        end
        check("flush_no_valid", 32'(saw_valid), 32'h0);
        @(posedge clk); #1;
        do_op("mul_3x4", F_MUL, 32'd3, 32'd4, 32'd12);

        // Asynchronous reset in cycle 20 of a MULHU
        StartE = 1'b1; funct3E = F_MULHU; SrcAE = 32'hFFFF_FFFF; SrcBE = 32'hFFFF_FFFF;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0; StartE = 1'b0;
        #1;
        check("arst_result", MulDivResultE, 32'h0);
        check("arst_valid", 32'(MulDivValidE), 32'h0);
        check("arst_stall", 32'(StallMD), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3);

        // Randomized ops, issued back to back
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            do_op("rand", rf, ra, rb, ref_md(rf, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
